// File: rtl/fpcvt_reg.sv
// ============================================================================
// Module   : fpcvt_reg
// Purpose  : Registered 12-bit two's-complement integer to 8-bit float code
//            {S, E[2:0], F[3:0]}, value = (-1)^S * F * 2^E, round-to-nearest
//            on a single round bit with saturation at the top of the range.
//            Optional macro FPCVT_SAT_FLAG_EN adds a registered 'sat' output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpcvt_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [11:0] D,
  output logic        out_valid,
  output logic        S,
  output logic [2:0]  E,
  output logic [3:0]  F
`ifdef FPCVT_SAT_FLAG_EN
  ,
  output logic        sat
`endif
);

  logic [10:0] mag;
  logic [2:0]  e0;
  logic [3:0]  f0;
  logic        rnd;
  logic [2:0]  e_next;
  logic [3:0]  f_next;

  // |D| always fits in 11 bits because -2048 is clamped to 2047.
  always_comb begin
    mag = D[10:0];
    if (D[11]) begin
      if (D[10:0] == 11'd0) begin
        mag = 11'h7FF;
      end else begin
        mag = ~D[10:0] + 11'd1;
      end
    end
  end

  // Locate the leading one; the 4 bits from it form the significand.
  always_comb begin
    e0  = 3'd0;
    f0  = mag[3:0];
    rnd = 1'b0;
    casez (mag[10:4])
      7'b1??????: begin e0 = 3'd7; f0 = mag[10:7]; rnd = mag[6]; end
      7'b01?????: begin e0 = 3'd6; f0 = mag[9:6];  rnd = mag[5]; end
      7'b001????: begin e0 = 3'd5; f0 = mag[8:5];  rnd = mag[4]; end
      7'b0001???: begin e0 = 3'd4; f0 = mag[7:4];  rnd = mag[3]; end
      7'b00001??: begin e0 = 3'd3; f0 = mag[6:3];  rnd = mag[2]; end
      7'b000001?: begin e0 = 3'd2; f0 = mag[5:2];  rnd = mag[1]; end
      7'b0000001: begin e0 = 3'd1; f0 = mag[4:1];  rnd = mag[0]; end
      default:    begin e0 = 3'd0; f0 = mag[3:0];  rnd = 1'b0;   end
    endcase
  end

  // Rounding; a carry out of the significand renormalises to 8 or saturates.
  always_comb begin
    e_next = e0;
    f_next = f0;
    if (rnd) begin
      if (f0 == 4'hF) begin
        if (e0 == 3'd7) begin
          e_next = 3'd7;
          f_next = 4'hF;
        end else begin
          e_next = e0 + 3'd1;
          f_next = 4'd8;
        end
      end else begin
        f_next = f0 + 4'd1;
      end
    end
  end

`ifdef FPCVT_SAT_FLAG_EN
  logic sat_next;
  assign sat_next = (D == 12'h800) || (rnd && (f0 == 4'hF) && (e0 == 3'd7));
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      S         <= 1'b0;
      E         <= 3'd0;
      F         <= 4'd0;
`ifdef FPCVT_SAT_FLAG_EN
      sat       <= 1'b0;
`endif
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        S <= D[11];
        E <= e_next;
        F <= f_next;
`ifdef FPCVT_SAT_FLAG_EN
        sat <= sat_next;
`endif
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fpcvt_reg.sv
// Testbench for fpcvt_reg: directed vectors plus a random stream against an
// arithmetic reference model.
`default_nettype none

module tb_fpcvt_reg;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [11:0] D;
  logic        out_valid;
  logic        S;
  logic [2:0]  E;
  logic [3:0]  F;
`ifdef FPCVT_SAT_FLAG_EN
  logic        sat;
`endif

  int total = 0;
  int bad   = 0;
  logic [8:0] held;  // {sat, S, E, F} expected to be held by the DUT

  fpcvt_reg dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .D         (D),
    .out_valid (out_valid),
    .S         (S),
    .E         (E),
    .F         (F)
`ifdef FPCVT_SAT_FLAG_EN
    ,
    .sat       (sat)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [11:0] DV [8] = '{12'h599, 12'hA72, 12'h800, 12'h55F,
                                     12'h3E0, 12'h000, 12'h005, 12'h07F};
  // {sat, S, E, F}
  localparam logic [8:0]  XV [8] = '{9'b0_0_111_1011, 9'b0_1_111_1011,
                                     9'b1_1_111_1111, 9'b0_0_111_1011,
                                     9'b0_0_111_1000, 9'b0_0_000_0000,
                                     9'b0_0_000_0101, 9'b0_0_100_1000};

  // Reference: pick the exponent so that |D| >> e lands in [8,16), round with
  // the next bit down, renormalise on carry and clamp at the top.
  function automatic logic [8:0] model(input logic [11:0] d);
    int v, m, e0, f, r, e;
    logic sf;
    v  = $signed(d);
    m  = (v < 0) ? -v : v;
    sf = 1'b0;
    if (m == 2048) begin
      m  = 2047;
      sf = 1'b1;
    end
    e0 = 0;
    while (e0 < 7 && m >= (16 << e0)) e0++;
    if (e0 == 0) begin
      f = m;
      r = 0;
    end else begin
      f = m >> e0;
      r = (m >> (e0 - 1)) & 1;
    end
    f = f + r;
    e = e0;
    if (f == 16) begin
      e = e + 1;
      f = 8;
    end
    if (e == 8) begin
      e  = 7;
      f  = 15;
      sf = 1'b1;
    end
    return {sf, d[11], 3'(e), 4'(f)};
  endfunction

  task test_reset;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    D        = 12'h599;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || {S, E, F} !== 8'h00) begin
      bad++;
      $display("FAIL reset: out_valid=%b S=%b E=%0d F=%0d, want 0/0/0/0", out_valid, S, E, F);
    end
`ifdef FPCVT_SAT_FLAG_EN
    total++;
    if (sat !== 1'b0) begin
      bad++;
      $display("FAIL reset_sat: sat=%b want 0", sat);
    end
`endif
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_idle: out_valid=%b want 0", out_valid);
    end
    in_valid = 1'b1;
    D        = 12'h599;
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || {S, E, F} !== 8'b0_111_1011) begin
      bad++;
      $display("FAIL first_result: out_valid=%b S=%b E=%0d F=%0d, want 1/0/7/11", out_valid, S, E, F);
    end
    held = 9'b0_0_111_1011;
  endtask

  task test_directed;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      D        = DV[i];
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || {S, E, F} !== XV[i][7:0]) begin
        bad++;
        $display("FAIL directed[%0d] D=%h: out_valid=%b S=%b E=%0d F=%0d, want 1/%b/%0d/%0d",
                 i, DV[i], out_valid, S, E, F, XV[i][7], XV[i][6:4], XV[i][3:0]);
      end
`ifdef FPCVT_SAT_FLAG_EN
      total++;
      if (sat !== XV[i][8]) begin
        bad++;
        $display("FAIL directed_sat[%0d]: sat=%b want %b", i, sat, XV[i][8]);
      end
`endif
      held = XV[i];
    end
    in_valid = 1'b0;
  endtask

  task test_back_to_back;
    logic [11:0] seq [3];
    logic [8:0]  x;
    seq[0] = 12'h7FF;
    seq[1] = 12'h010;
    seq[2] = 12'hFFF;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      D        = seq[i];
      x        = model(seq[i]);
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || {S, E, F} !== x[7:0]) begin
        bad++;
        $display("FAIL stream[%0d] D=%h: out_valid=%b SEF=%h, want 1/%h", i, seq[i], out_valid, {S, E, F}, x[7:0]);
      end
      held = x;
    end
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b0;
      D        = 12'($urandom);
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || {S, E, F} !== held[7:0]) begin
        bad++;
        $display("FAIL stream_hold[%0d]: out_valid=%b SEF=%h, want 0/%h", i, out_valid, {S, E, F}, held[7:0]);
      end
    end
  endtask

  task test_random;
    logic        v;
    logic [11:0] d;
    for (int n = 0; n < 400; n++) begin
      v = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        0:       d = 12'h800;
        1:       d = 12'h7FF;
        2:       d = 12'($urandom_range(0, 40));
        default: d = 12'($urandom);
      endcase
      in_valid = v;
      D        = d;
      @(negedge clk);
      if (v) held = model(d);
      total++;
      if (out_valid !== v || {S, E, F} !== held[7:0]) begin
        bad++;
        $display("FAIL random[%0d] v=%b D=%h: out_valid=%b SEF=%h, want %b/%h", n, v, d, out_valid, {S, E, F}, v, held[7:0]);
      end
`ifdef FPCVT_SAT_FLAG_EN
      total++;
      if (sat !== held[8]) begin
        bad++;
        $display("FAIL random_sat[%0d] D=%h: sat=%b want %b", n, d, sat, held[8]);
      end
`endif
    end
    in_valid = 1'b0;
  endtask

  initial begin
    held = 9'd0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
